// File: rtl/descent_multistart_ctrl_pkg.sv
// Shared Q16.16 limits, sequencer state encoding and the saturating adder.
package descent_multistart_ctrl_pkg;

    localparam int          FIX_W   = 32;
    localparam logic [31:0] FIX_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] FIX_MIN = 32'h8000_0000;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_RELEASE   = 3'd3,
        S_FINISH    = 3'd4
    } state_t;

    // Signed Q16.16 add/subtract that clamps to FIX_MAX/FIX_MIN instead of wrapping.
    function automatic logic [FIX_W-1:0] fixed_32_add_sub(
        input logic [FIX_W-1:0] a,
        input logic [FIX_W-1:0] b,
        input logic             sub
    );
        logic [FIX_W:0] sum;
        sum = sub ? ({a[FIX_W-1], a} - {b[FIX_W-1], b})
                  : ({a[FIX_W-1], a} + {b[FIX_W-1], b});
        if (sum[FIX_W] != sum[FIX_W-1]) begin
            return sum[FIX_W] ? FIX_MIN : FIX_MAX;
        end
        return sum[FIX_W-1:0];
    endfunction

endpackage

// File: rtl/descent_multistart_ctrl_min_tracker.sv
// Keeps the lowest signed y seen since the last clear, with its x and job index.
module descent_multistart_ctrl_min_tracker
    import descent_multistart_ctrl_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             valid,
    input  logic [31:0]      x_in,
    input  logic [31:0]      y_in,
    input  logic [IDX_W-1:0] idx_in,
    output logic [31:0]      best_x,
    output logic [31:0]      best_y,
    output logic [IDX_W-1:0] best_idx
);

    logic             have_q, have_d;
    logic [31:0]      best_x_q, best_x_d;
    logic [31:0]      best_y_q, best_y_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;

    // Load on the first result after a clear, then only on a strictly lower y
    // so a tie keeps the earlier index.
    always_comb begin
        have_d     = have_q;
        best_x_d   = best_x_q;
        best_y_d   = best_y_q;
        best_idx_d = best_idx_q;
        if (clear) begin
            have_d     = 1'b0;
            best_x_d   = '0;
            best_y_d   = '0;
            best_idx_d = '0;
        end else if (valid && (!have_q || ($signed(y_in) < $signed(best_y_q)))) begin
            have_d     = 1'b1;
            best_x_d   = x_in;
            best_y_d   = y_in;
            best_idx_d = idx_in;
        end
    end

    // Result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            have_q     <= 1'b0;
            best_x_q   <= '0;
            best_y_q   <= '0;
            best_idx_q <= '0;
        end else begin
            have_q     <= have_d;
            best_x_q   <= best_x_d;
            best_y_q   <= best_y_d;
            best_idx_q <= best_idx_d;
        end
    end

    assign best_x   = best_x_q;
    assign best_y   = best_y_q;
    assign best_idx = best_idx_q;

endmodule

// File: rtl/descent_multistart_ctrl.sv
// Multi-start job sequencer for one gradient-descent core.
//
//  state       | meaning
//  ------------+-----------------------------------------------------------
//  S_IDLE      | waiting for go; captures base/step and clears results
//  S_ISSUE     | raise opt_start once the core's done is low
//  S_WAIT_DONE | opt_start held; capture result on opt_done or time out
//  S_RELEASE   | opt_start low; wait for opt_done to fall, advance x and k
//  S_FINISH    | one-cycle done pulse, back to idle
module descent_multistart_ctrl
    import descent_multistart_ctrl_pkg::*;
#(
    parameter  int NUM_STARTS     = 8,
    parameter  int TIMEOUT_CYCLES = 4096,
    localparam int IDX_W          = $clog2(NUM_STARTS + 1),
    localparam int TMR_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [31:0]      base_x,
    input  logic [31:0]      step_x,
    output logic             opt_start,
    output logic [31:0]      opt_x_init,
    input  logic             opt_done,
    input  logic [31:0]      opt_x_at_min,
    input  logic [31:0]      opt_y_min,
    output logic [31:0]      best_x,
    output logic [31:0]      best_y,
    output logic [IDX_W-1:0] best_idx,
    output logic             busy,
    output logic             done,
    output logic             timeout_err
);

    state_t           state_q, state_d;
    logic [31:0]      x_q, x_d;
    logic [31:0]      step_q, step_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             terr_q, terr_d;
    logic             trk_clear, trk_valid;
    logic             timed_out;

    // Down-counter hits terminal count after TIMEOUT_CYCLES cycles in one state.
    assign timed_out = (timer_q == '0);

    // Next-state, datapath and handshake outputs. Completion is tested before
    // the timeout so a same-cycle opt_done wins.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        step_d    = step_q;
        k_d       = k_q;
        terr_d    = terr_q;
        trk_clear = 1'b0;
        trk_valid = 1'b0;
        opt_start = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (go) begin
                    x_d       = base_x;
                    step_d    = step_x;
                    k_d       = '0;
                    terr_d    = 1'b0;
                    trk_clear = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!opt_done) begin
                    opt_start = 1'b1;
                    state_d   = S_WAIT_DONE;
                end else if (timed_out) begin
                    terr_d  = 1'b1;
                    state_d = S_FINISH;
                end
            end
            S_WAIT_DONE: begin
                opt_start = 1'b1;
                if (opt_done) begin
                    trk_valid = 1'b1;
                    state_d   = S_RELEASE;
                end else if (timed_out) begin
                    terr_d  = 1'b1;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!opt_done) begin
                    k_d     = k_q + IDX_W'(1);
                    x_d     = fixed_32_add_sub(x_q, step_q, 1'b0);
                    state_d = (k_q == IDX_W'(NUM_STARTS - 1)) ? S_FINISH : S_ISSUE;
                end else if (timed_out) begin
                    terr_d  = 1'b1;
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
        if (state_d != state_q) begin
            timer_d = TMR_W'(TIMEOUT_CYCLES - 1);
        end else if (timed_out) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q - TMR_W'(1);
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            step_q  <= '0;
            k_q     <= '0;
            timer_q <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            step_q  <= step_d;
            k_q     <= k_d;
            timer_q <= timer_d;
            terr_q  <= terr_d;
        end
    end

    assign opt_x_init  = x_q;
    assign timeout_err = terr_q;

    descent_multistart_ctrl_min_tracker #(
        .IDX_W (IDX_W)
    ) u_min_tracker (
        .clk      (clk),
        .rst      (rst),
        .clear    (trk_clear),
        .valid    (trk_valid),
        .x_in     (opt_x_at_min),
        .y_in     (opt_y_min),
        .idx_in   (k_q),
        .best_x   (best_x),
        .best_y   (best_y),
        .best_idx (best_idx)
    );

endmodule

// File: tb/tb_descent_multistart_ctrl.sv
// Bench for descent_multistart_ctrl with a behavioural descent-core model.
module tb_descent_multistart_ctrl;

    localparam int N  = 4;
    localparam int TO = 4096;
    localparam int IW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          go = 1'b0;
    logic [31:0]   base_x = '0;
    logic [31:0]   step_x = '0;
    logic          opt_start;
    logic [31:0]   opt_x_init;
    logic          opt_done = 1'b0;
    logic [31:0]   opt_x_at_min = '0;
    logic [31:0]   opt_y_min = '0;
    logic [31:0]   best_x, best_y;
    logic [IW-1:0] best_idx;
    logic          busy, done, timeout_err;

    descent_multistart_ctrl #(
        .NUM_STARTS     (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .go           (go),
        .base_x       (base_x),
        .step_x       (step_x),
        .opt_start    (opt_start),
        .opt_x_init   (opt_x_init),
        .opt_done     (opt_done),
        .opt_x_at_min (opt_x_at_min),
        .opt_y_min    (opt_y_min),
        .best_x       (best_x),
        .best_y       (best_y),
        .best_idx     (best_idx),
        .busy         (busy),
        .done         (done),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Controls owned by the main sequence.
    int          y_mode = 0;
    int          hang_job = -1;
    int          sweep_j0 = 0;
    bit          force_done = 1'b0;
    logic [31:0] rnd_y [N];

    // State owned by the core model.
    logic [31:0] obs_x [$];
    int          job_cnt = 0;
    int          done_cnt = 0;
    int          hang_start_cycles = 0;
    bit          cm_active = 1'b0;
    int          cm_up = 0;
    int          cm_dn = 0;
    logic [31:0] cm_x = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat_add_ref(input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        if (s > 64'sh7FFF_FFFF) return 32'h7FFF_FFFF;
        if (s < -64'sh8000_0000) return 32'h8000_0000;
        return s[31:0];
    endfunction

    function automatic logic [31:0] model_y(input int mode, input logic [31:0] x, input int rel);
        longint d, p;
        if (mode == 1) return 32'h0005_0000;
        if (mode == 2) return rnd_y[rel];
        d = longint'($signed(x)) - 64'sd131072;
        p = (d * d) >>> 16;
        if (p > 64'sh7FFF_FFFF) return 32'h7FFF_FFFF;
        return p[31:0];
    endfunction

    // Core model: acts on the falling edge, latency 1..6 cycles up, 0..3 down.
    initial forever begin
        @(negedge clk);
        if (done) done_cnt++;
        if (force_done) begin
            opt_done  = 1'b1;
            cm_dn     = 0;
            cm_active = 1'b0;
        end else if (opt_done) begin
            if (!opt_start) begin
                if (cm_dn == 0) begin
                    opt_done  = 1'b0;
                    cm_active = 1'b0;
                end else begin
                    cm_dn--;
                end
            end
        end else if (opt_start) begin
            if (!cm_active) begin
                cm_active = 1'b1;
                cm_x      = opt_x_init;
                obs_x.push_back(opt_x_init);
                cm_up     = int'($urandom_range(1, 6));
                cm_dn     = int'($urandom_range(0, 3));
                job_cnt++;
            end
            if (job_cnt - 1 == hang_job) begin
                hang_start_cycles++;
            end else if (cm_up == 0) begin
                opt_done     = 1'b1;
                opt_x_at_min = cm_x ^ 32'h0000_00A5;
                opt_y_min    = model_y(y_mode, cm_x, job_cnt - 1 - sweep_j0);
            end else begin
                cm_up--;
            end
        end else begin
            cm_active = 1'b0;
        end
    end

    task automatic run_sweep(input string tag, input logic [31:0] base, input logic [31:0] step,
                             input int mode, input int hang_rel, input int pre_force);
        int          j0, d0, h0, cyc, bi, exp_jobs;
        bit          have, saw_start, aborted, exp_terr;
        logic [31:0] ex [N];
        logic [31:0] bx, by, y;
        j0       = job_cnt;
        d0       = done_cnt;
        h0       = hang_start_cycles;
        sweep_j0 = j0;
        y_mode   = mode;
        hang_job = (hang_rel >= 0) ? j0 + hang_rel : -1;
        for (int k = 0; k < N; k++) begin
            int t;
            t = int'($urandom_range(0, 7)) - 4;
            rnd_y[k] = 32'(t * 65536);
        end
        if (pre_force > 0) begin
            force_done = 1'b1;
            @(negedge clk);
        end
        base_x = base;
        step_x = step;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        chk({tag, " busy_after_go"}, {31'd0, busy}, 32'd1);
        if (pre_force > 0) begin
            saw_start = 1'b0;
            for (int c = 0; c < pre_force && !done; c++) begin
                if (opt_start) saw_start = 1'b1;
                @(negedge clk);
            end
            chk({tag, " no_start_while_stale"}, {31'd0, saw_start}, 32'd0);
            force_done = 1'b0;
        end
        cyc = 0;
        while (!done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " done_seen"}, {31'd0, done}, 32'd1);
        chk({tag, " busy_low_at_done"}, {31'd0, busy}, 32'd0);
        repeat (8) @(negedge clk);
        chk({tag, " one_done_pulse"}, 32'(done_cnt - d0), 32'd1);

        aborted  = (pre_force > TO + 2);
        exp_jobs = aborted ? 0 : N;
        exp_terr = aborted || (hang_rel >= 0 && hang_rel < N);
        ex[0] = base;
        for (int k = 1; k < N; k++) ex[k] = sat_add_ref(ex[k-1], step);
        have = 1'b0; bx = '0; by = '0; bi = 0;
        for (int k = 0; k < exp_jobs; k++) begin
            if (k != hang_rel) begin
                y = model_y(mode, ex[k], k);
                if (!have || $signed(y) < $signed(by)) begin
                    have = 1'b1;
                    bx   = ex[k] ^ 32'h0000_00A5;
                    by   = y;
                    bi   = k;
                end
            end
        end
        chk({tag, " jobs_issued"}, 32'(job_cnt - j0), 32'(exp_jobs));
        for (int k = 0; k < exp_jobs && j0 + k < obs_x.size(); k++)
            chk($sformatf("%s x_init[%0d]", tag, k), obs_x[j0 + k], ex[k]);
        chk({tag, " best_x"}, best_x, bx);
        chk({tag, " best_y"}, best_y, by);
        chk({tag, " best_idx"}, 32'(best_idx), 32'(bi));
        chk({tag, " timeout_err"}, {31'd0, timeout_err}, {31'd0, exp_terr});
        if (hang_rel >= 0 && hang_rel < N) begin
            cyc = hang_start_cycles - h0;
            chk({tag, " hang_start_len_ok"}, {31'd0, (cyc >= TO && cyc <= TO + 2)}, 32'd1);
        end
        hang_job = -1;
    endtask

    initial begin
        int j0, d0;
        repeat (3) @(negedge clk);
        chk("rst opt_start", {31'd0, opt_start}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst opt_x_init", opt_x_init, 32'd0);
        chk("rst best_y", best_y, 32'd0);
        chk("rst timeout_err", {31'd0, timeout_err}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_sweep("t1_parabola", 32'h0000_0000, 32'h0001_0000, 0, -1, 0);
        chk("t1 best_idx_is_2", 32'(best_idx), 32'd2);
        run_sweep("t2_tie", 32'h0003_0000, 32'hFFFF_0000, 1, -1, 0);
        run_sweep("t3_sat_hi", 32'h7FFF_0000, 32'h0001_0000, 0, -1, 0);
        run_sweep("t3_sat_lo", 32'h8001_0000, 32'hFFFE_0000, 2, -1, 0);
        run_sweep("t4_hang", 32'h0000_0000, 32'h0001_0000, 0, 1, 0);
        run_sweep("t4_clear", 32'h0001_0000, 32'h0000_8000, 0, -1, 0);
        run_sweep("t5_stale", 32'h0002_0000, 32'h0000_4000, 2, -1, 20);
        run_sweep("t7_abort", 32'h0002_0000, 32'h0000_4000, 0, -1, TO + 200);

        // Reset while a job is outstanding; a second go during the job is ignored.
        j0 = job_cnt;
        d0 = done_cnt;
        sweep_j0 = j0;
        hang_job = j0;
        base_x = 32'h1234_0000;
        step_x = 32'h0001_0000;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (10) @(negedge clk);
        chk("t6 start_held", {31'd0, opt_start}, 32'd1);
        base_x = 32'h5555_0000;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        @(negedge clk);
        chk("t6 go_ignored_x", opt_x_init, 32'h1234_0000);
        chk("t6 go_ignored_busy", {31'd0, busy}, 32'd1);
        chk("t6 go_ignored_jobs", 32'(job_cnt - j0), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6 rst opt_start", {31'd0, opt_start}, 32'd0);
        chk("t6 rst busy", {31'd0, busy}, 32'd0);
        chk("t6 rst opt_x_init", opt_x_init, 32'd0);
        chk("t6 rst best_x", best_x, 32'd0);
        chk("t6 rst best_idx", 32'(best_idx), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        hang_job = -1;
        repeat (10) @(negedge clk);
        chk("t6 no_done_after_rst", 32'(done_cnt - d0), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_sweep($sformatf("rnd%0d", i), $urandom(), $urandom(), (i % 2 == 0) ? 2 : 0, -1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
